// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first over WIDTH bits.
// Optional signed-overflow output is compiled in with `define SERIAL_ADDER_OVERFLOW_EN.

module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | ((x ^ y) & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH:0]   res_cat;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s, fa_co;

  serial_adder_fa u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign res_cat = {fa_s, res_sr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        // a held start is taken straight from DONE so back-to-back ops need no idle gap
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= carryin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_cat[WIDTH:1];
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
    end
  end

  assign sum      = res_sr;
  assign carryout = carry;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // on the last bit the carry flop holds the carry into the MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      overflow <= 1'b0;
    else if (state == RUN && last)  overflow <= carry ^ fa_co;
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8; overflow cases only when the macro is set.

module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             carryin;
  logic             busy, done, carryout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus only: accepts one op, then watches 30 edges. lat is the edge index
  // (after the accepting edge) following which done is first seen high.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output int lat, output int bcnt, output int dcnt,
                        output logic [7:0] s_done, output logic c_done);
    @(negedge clk);
    a = ta; b = tb_v; carryin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0; dcnt = 0; s_done = 8'hxx; c_done = 1'bx;
    if (busy) bcnt++;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = i; s_done = sum; c_done = carryout;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; carryin = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", carryout); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bcnt, dcnt; logic [7:0] s; logic c;
    run_op(8'h0F, 8'h01, 1'b0, lat, bcnt, dcnt, s, c);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dcnt); end
    checks++; if (s !== 8'h10) begin errors++; $display("FAIL basic_sum got %h want 10", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout got %b want 0", c); end
    checks++; if (sum !== 8'h10) begin errors++; $display("FAIL basic_sum_held got %h want 10", sum); end
  endtask

  task automatic test_carry;
    int lat, bcnt, dcnt; logic [7:0] s; logic c;
    run_op(8'hFF, 8'h01, 1'b0, lat, bcnt, dcnt, s, c);
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL carry_ff_sum got %h want 00", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry_ff_cout got %b want 1", c); end
    run_op(8'h00, 8'h00, 1'b1, lat, bcnt, dcnt, s, c);
    checks++; if (s !== 8'h01) begin errors++; $display("FAIL carry_cin_sum got %h want 01", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL carry_cin_cout got %b want 0", c); end
  endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
  task automatic test_overflow;
    int lat, bcnt, dcnt; logic [7:0] s; logic c;
    run_op(8'h7F, 8'h01, 1'b0, lat, bcnt, dcnt, s, c);
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL ovf_7f_sum got %h want 80", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf_7f_cout got %b want 0", c); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_7f_flag got %b want 1", overflow); end
    run_op(8'hFF, 8'hFF, 1'b0, lat, bcnt, dcnt, s, c);
    checks++; if (s !== 8'hFE) begin errors++; $display("FAIL ovf_ff_sum got %h want fe", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf_ff_cout got %b want 1", c); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_ff_flag got %b want 0", overflow); end
  endtask
`endif

  task automatic test_busy_start;
    int lat = 0, dcnt = 0; logic [7:0] s = 8'hxx;
    @(negedge clk);
    a = 8'h10; b = 8'h20; carryin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; a = 8'h55; end
      else begin start = 1'b0; a = 8'h10; end
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        if (lat == 0) begin lat = i; s = sum; end
      end
    end
    start = 1'b0;
    checks++; if (lat !== 8) begin errors++; $display("FAIL busy_start_latency got %0d want 8", lat); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL busy_start_done_pulses got %0d want 1", dcnt); end
    checks++; if (s !== 8'h30) begin errors++; $display("FAIL busy_start_sum got %h want 30", s); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dcnt; logic [7:0] s; logic c;
    @(negedge clk);
    a = 8'h0B; b = 8'h01; carryin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL midreset_sum got %h want 00", sum); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL midreset_cout got %b want 0", carryout); end
    @(negedge clk); reset = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, lat, bcnt, dcnt, s, c);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midreset_latency got %0d want 8", lat); end
    checks++; if (s !== 8'h07) begin errors++; $display("FAIL midreset_sum_after got %h want 07", s); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL midreset_done_pulses got %0d want 1", dcnt); end
  endtask

  task automatic test_back_to_back;
    int d1 = 0, d2 = 0, dcnt = 0; logic [7:0] s1 = 8'hxx, s2 = 8'hxx;
    @(negedge clk);
    a = 8'h01; b = 8'h01; carryin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h02; b = 8'h02;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = i; s1 = sum; end
        else if (dcnt == 2) begin d2 = i; s2 = sum; end
      end
      if (i == 16) start = 1'b0;
    end
    checks++; if (dcnt !== 2) begin errors++; $display("FAIL b2b_done_pulses got %0d want 2", dcnt); end
    checks++; if (d1 !== 8) begin errors++; $display("FAIL b2b_first_done got %0d want 8", d1); end
    checks++; if (d2 - d1 !== 9) begin errors++; $display("FAIL b2b_spacing got %0d want 9", d2 - d1); end
    checks++; if (s1 !== 8'h02) begin errors++; $display("FAIL b2b_sum1 got %h want 02", s1); end
    checks++; if (s2 !== 8'h04) begin errors++; $display("FAIL b2b_sum2 got %h want 04", s2); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    test_overflow;
`endif
    test_busy_start;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
